// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: host-side byte queue feeding a UART transmitter through a start/done handshake.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_host_data,
    input  logic                 i_write_en,
    input  logic                 i_ovf_clear,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_fifo_empty,
    output logic                 o_fifo_full,
    output logic                 o_fifo_overflow,
    output logic [CNT_W-1:0]     o_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;
    state_t               r_state;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx_start, r_ovf;
    logic                 w_pop, w_push, w_full;
    assign w_full          = r_count == CNT_W'(FIFO_DEPTH);
    assign w_pop           = r_state == IDLE && r_count != '0 && !i_tx_busy;
    // a pop on the same edge frees a slot, so a write into a full queue still lands
    assign w_push          = i_write_en && (!w_full || w_pop);
    assign o_tx_data       = r_tx_data;
    assign o_tx_start      = r_tx_start;
    assign o_fifo_empty    = r_count == '0;
    assign o_fifo_full     = w_full;
    assign o_fifo_overflow = r_ovf;
    assign o_count         = r_count;
    always_ff @(posedge i_clock)
        if (w_push) r_mem[r_wptr] <= i_host_data;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            if (w_pop) r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (i_write_en && !w_push) r_ovf <= 1'b1;
            else if (i_ovf_clear) r_ovf <= 1'b0;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_tx_data  <= r_mem[r_rptr];
                    r_tx_start <= 1'b1;
                    r_state    <= START;
                end
                START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_DONE;
                end
                WAIT_DONE: if (i_tx_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenario tasks with hand-computed expectations for uart_tx_fifo.
module tb_uart_tx_fifo;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] host_data = '0;
    logic       write_en = 1'b0, ovf_clear = 1'b0, tx_busy = 1'b0, tx_done = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start, fifo_empty, fifo_full, fifo_overflow;
    logic [2:0] count;
    int checks = 0, errors = 0;

    uart_tx_fifo dut (
        .i_clock(clk), .i_reset(rst), .i_host_data(host_data), .i_write_en(write_en),
        .i_ovf_clear(ovf_clear), .i_tx_busy(tx_busy), .i_tx_done(tx_done),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_fifo_empty(fifo_empty),
        .o_fifo_full(fifo_full), .o_fifo_overflow(fifo_overflow), .o_count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++; if ({tx_start, fifo_empty, fifo_full, fifo_overflow} !== 4'b0100) begin errors++; $display("FAIL reset_flags got %b want 0100", {tx_start, fifo_empty, fifo_full, fifo_overflow}); end
        checks++; if (count !== 3'd0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_count_data got count=%0d data=%h want 0/00", count, tx_data); end
    endtask

    task automatic test_single();
        host_data = 8'hA5; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        checks++; if (fifo_empty !== 1'b0 || count !== 3'd1 || tx_start !== 1'b0) begin errors++; $display("FAIL single_after_write got empty=%b count=%0d start=%b want 0/1/0", fifo_empty, count, tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5 || count !== 3'd0) begin errors++; $display("FAIL single_launch got start=%b data=%h count=%0d want 1/a5/0", tx_start, tx_data, count); end
        tick();
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'hA5 || fifo_empty !== 1'b1) begin errors++; $display("FAIL single_pulse_end got start=%b data=%h empty=%b want 0/a5/1", tx_start, tx_data, fifo_empty); end
        tick();
        pulse_done();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        write_en = 1'b1; host_data = 8'h11;
        tick();
        host_data = 8'h22;
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL b2b_first got start=%b data=%h want 1/11", tx_start, tx_data); end
        host_data = 8'h33;
        tick();
        write_en = 1'b0;
        checks++; if (tx_start !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL b2b_queued got start=%b count=%0d want 0/2", tx_start, count); end
        for (int i = 1; i < 3; i++) begin
            repeat (8) tick();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL b2b_no_launch_while_waiting got %b want 0", tx_start); end
            pulse_done();
            checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL b2b_gap got start=%b want 0", tx_start); end
            tick();
            checks++; if (tx_start !== 1'b1 || tx_data !== exp[i]) begin errors++; $display("FAIL b2b_frame%0d got start=%b data=%h want 1/%h", i, tx_start, tx_data, exp[i]); end
        end
        repeat (9) tick();
        pulse_done();
        tick();
        checks++; if (fifo_empty !== 1'b1 || count !== 3'd0 || tx_start !== 1'b0) begin errors++; $display("FAIL b2b_end got empty=%b count=%0d start=%b want 1/0/0", fifo_empty, count, tx_start); end
    endtask

    task automatic test_overflow();
        tx_busy = 1'b1;
        write_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_data = 8'h41 + 8'(i);
            tick();
        end
        checks++; if (fifo_full !== 1'b1 || count !== 3'd4 || fifo_overflow !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%b count=%0d ovf=%b start=%b want 1/4/0/0", fifo_full, count, fifo_overflow, tx_start); end
        host_data = 8'h45;
        tick();
        write_en = 1'b0;
        checks++; if (fifo_overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_drop got ovf=%b count=%0d want 1/4", fifo_overflow, count); end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", fifo_overflow); end
        write_en = 1'b1; ovf_clear = 1'b1; host_data = 8'hEE;
        tick();
        write_en = 1'b0; ovf_clear = 1'b0;
        checks++; if (fifo_overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_set_wins got ovf=%b count=%0d want 1/4", fifo_overflow, count); end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        repeat (3) tick();
        checks++; if (tx_start !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL ovf_busy_stall got start=%b count=%0d want 0/4", tx_start, count); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp [4] = '{8'h42, 8'h43, 8'h44, 8'h99};
        tx_busy = 1'b0; write_en = 1'b1; host_data = 8'h99;
        tick();
        write_en = 1'b0;
        checks++; if (count !== 3'd4 || fifo_overflow !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL simul_push_pop got count=%0d ovf=%b start=%b data=%h want 4/0/1/41", count, fifo_overflow, tx_start, tx_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            pulse_done();
            tick();
            checks++; if (tx_start !== 1'b1 || tx_data !== exp[i]) begin errors++; $display("FAIL simul_order%0d got start=%b data=%h want 1/%h", i, tx_start, tx_data, exp[i]); end
        end
        tick();
        pulse_done();
        tick();
        checks++; if (fifo_empty !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL simul_drained got empty=%b start=%b want 1/0", fifo_empty, tx_start); end
    endtask

    task automatic test_reset_mid();
        write_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_data = 8'h51 + 8'(i);
            tick();
        end
        write_en = 1'b0;
        tick();
        checks++; if (count !== 3'd2 || tx_data !== 8'h51) begin errors++; $display("FAIL midrst_setup got count=%0d data=%h want 2/51", count, tx_data); end
        rst = 1'b1;
        #2;
        checks++; if (count !== 3'd0 || tx_data !== 8'h00 || {tx_start, fifo_empty, fifo_full, fifo_overflow} !== 4'b0100) begin errors++; $display("FAIL midrst_async got count=%0d data=%h flags=%b want 0/00/0100", count, tx_data, {tx_start, fifo_empty, fifo_full, fifo_overflow}); end
        tick();
        rst = 1'b0;
        pulse_done();
        repeat (3) begin
            tick();
            checks++; if (tx_start !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst_no_launch got start=%b empty=%b want 0/1", tx_start, fifo_empty); end
        end
    endtask

    task automatic test_stream();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int t = 0; t < 200 && fifo_full; t++) tick();
                    write_en = 1'b1; host_data = 8'h60 + 8'(i);
                    tick();
                    write_en = 1'b0;
                end
            end
            begin
                for (int n = 0; n < 10; n++) begin
                    int t = 0;
                    while (tx_start !== 1'b1 && t < 300) begin tick(); t++; end
                    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h60 + 8'(n)) begin errors++; $display("FAIL stream_byte%0d got start=%b data=%h want 1/%h", n, tx_start, tx_data, 8'h60 + 8'(n)); end
                    repeat ($urandom_range(1, 7)) tick();
                    pulse_done();
                end
            end
        join
        tick();
        checks++; if (fifo_overflow !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL stream_end got ovf=%b empty=%b want 0/1", fifo_overflow, fifo_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Clocked transmit-side buffer between the host and the UART transmitter, the write-direction counterpart of the receive FIFO. The host pushes bytes with single-cycle write strobes. A small state machine pops bytes in order and hands each to the transmitter with a one-cycle start pulse, then waits for the transmitter's done pulse before launching the next. Full, empty, overflow and occupancy flags are exported to the host.

Parameters:
DATA_BITS, 8, width of each data word
FIFO_DEPTH, 4, number of entries (any integer >= 2; pointers wrap at FIFO_DEPTH, not at a power of two)
CNT_W, $clog2(FIFO_DEPTH+1), width of occupancy count (derived, do not override)

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
Host_Data  in  DATA_BITS  byte to enqueue
Write_En  in  1  one-cycle write strobe; Host_Data sampled on same edge
Ovf_Clear  in  1  clears sticky FIFO_Overflow
Tx_Busy  in  1  transmitter busy level; no launch while high
Tx_Done  in  1  one-cycle pulse from transmitter when a frame (stop bit) completes
Tx_Data  out  DATA_BITS  byte presented to transmitter
Tx_Start  out  1  one-cycle launch pulse, registered
FIFO_Empty  out  1  high when Count == 0
FIFO_Full  out  1  high when Count == FIFO_DEPTH
FIFO_Overflow  out  1  sticky: a write was dropped
Count  out  CNT_W  current occupancy

Behaviour:
- Reset (async assert, sync release): WPtr = RPtr = 0, Count = 0, state IDLE, Tx_Data = 0, Tx_Start = 0, FIFO_Empty = 1, FIFO_Full = 0, FIFO_Overflow = 0. Reset mid-operation discards all queued data and any in-flight handshake. Storage array contents need not be reset.
- Flags are combinational decodes of the registered Count.
- Push: Write_En=1 and (not full, or a pop occurs on the same edge). Array[WPtr] <= Host_Data, WPtr advances with wrap FIFO_DEPTH-1 -> 0.
- Dropped write: Write_En=1 while full with no same-edge pop. Data is discarded, pointers and Count are unchanged, FIFO_Overflow <= 1.
- FIFO_Overflow stays set until Ovf_Clear=1. If a set and a clear occur on the same edge, the set wins.
- Pop occurs only on the IDLE->START transition, never elsewhere. RPtr advances with wrap.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop (including at full and at empty: a pop from empty cannot occur).
- FSM states:
  - IDLE: if Count>0 and Tx_Busy=0 -> START. Tx_Data <= Array[RPtr], pop, Tx_Start <= 1.
  - START (1 cycle): Tx_Start <= 0 -> WAIT_DONE.
  - WAIT_DONE: on Tx_Done=1 -> IDLE, else hold.
- Tx_Data holds its value from the Tx_Start cycle until the next launch.
- Tx_Done is ignored in IDLE and START.
- Latency: a write to an empty FIFO on edge k gives FIFO_Empty=0 after edge k. Tx_Start is high for the single cycle after edge k+1, provided Tx_Busy=0.
- Back-to-back frames: Tx_Done seen on edge j -> IDLE. The next Tx_Start is high after edge j+1, so there is a one-cycle minimum gap.
- Tx_Busy high in IDLE stalls the launch indefinitely; data is retained.
- Writes are accepted in every FSM state.

Test Plan:
- Reset, then write 0xA5 with Tx_Busy=0 -> FIFO_Empty falls 1 cycle after the write; Tx_Start is a single-cycle pulse 2 cycles after the write with Tx_Data=0xA5; Count returns to 0.
- Write 0x11,0x22,0x33 back-to-back; pulse Tx_Done 10 cycles after each Tx_Start -> three Tx_Start pulses carrying 0x11,0x22,0x33 in order, each 2 cycles after the preceding Tx_Done; FIFO_Empty=1 at the end.
- Hold Tx_Busy=1, write 5 bytes with FIFO_DEPTH=4 -> FIFO_Full=1 after the 4th write, 5th byte dropped, FIFO_Overflow=1, Count=4. Pulse Ovf_Clear -> FIFO_Overflow=0.
- Full FIFO, Tx_Busy drops, and a write lands on the same edge as the pop -> write accepted, Count stays 4, FIFO_Overflow stays 0; the new byte emerges 4th.
- Assert Reset during WAIT_DONE with 2 bytes queued -> all outputs return to their reset values immediately; a later Tx_Done produces no Tx_Start.
- Stream 10 bytes through depth 4 with random Tx_Done delays -> output order matches input order across pointer wrap, and no overflow is flagged.
